// File: rtl/morse_char_decoder.sv
// Morse token to ASCII decoder: input token FIFO, table decode, word-gap collapsing FSM
// and a registered AXI-stream master output stage.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_START  | nothing emitted since reset/clear; gap tokens are swallowed
// ST_IN_WORD| last emitted beat was a character; a gap emits one space
// ST_AFTER_GAP | last emitted beat was a space; further gaps are swallowed
module morse_char_decoder #(
  parameter int FIFO_DEPTH             = 8,
  parameter int UNKNOWN_DROP           = 0,
  parameter int ERR_CNT_W              = 8,
  parameter int MORSE_CHAR_WIDTH_MAX_C = 5,
  parameter int MORSE_SIZE_WIDTH_MAX_C = 3
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              s_tvalid_i,
  input  logic [MORSE_CHAR_WIDTH_MAX_C-1:0] s_tdata_i,
  input  logic [MORSE_SIZE_WIDTH_MAX_C-1:0] s_tsize_i,
  output logic                              m_tvalid_o,
  output logic [7:0]                        m_tdata_o,
  input  logic                              m_tready_i,
  output logic                              overflow_o,
  output logic [ERR_CNT_W-1:0]              err_cnt_o,
  input  logic                              clear_i
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TOK_W = MORSE_CHAR_WIDTH_MAX_C + MORSE_SIZE_WIDTH_MAX_C;

  typedef enum logic [1:0] {
    ST_START     = 2'd0,
    ST_IN_WORD   = 2'd1,
    ST_AFTER_GAP = 2'd2
  } state_t;

  state_t state;
  state_t nxt_state;

  logic [TOK_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_ok;
  logic push_drop;

  logic [TOK_W-1:0]                  head;
  logic [MORSE_CHAR_WIDTH_MAX_C-1:0] head_data;
  logic [MORSE_SIZE_WIDTH_MAX_C-1:0] head_size;
  logic                              head_is_char;
  logic [2:0]                        sz3;
  logic [4:0]                        code_raw;
  logic [4:0]                        code_mask;
  logic [4:0]                        code;
  logic [7:0]                        lookup_ch;

  logic       emit;
  logic [7:0] emit_ch;
  logic       unknown;

  // Returns 0 when the pattern has no table entry.
  function automatic logic [7:0] morse_lookup(input logic [2:0] size, input logic [4:0] c);
    logic [7:0] ch;
    ch = 8'h00;
    case (size)
      3'd1: case (c)
        5'd0: ch = "E";
        5'd1: ch = "T";
        default: ch = 8'h00;
      endcase
      3'd2: case (c)
        5'd0: ch = "I";
        5'd1: ch = "N";
        5'd2: ch = "A";
        5'd3: ch = "M";
        default: ch = 8'h00;
      endcase
      3'd3: case (c)
        5'd0: ch = "S";
        5'd1: ch = "D";
        5'd2: ch = "R";
        5'd3: ch = "G";
        5'd4: ch = "U";
        5'd5: ch = "K";
        5'd6: ch = "W";
        5'd7: ch = "O";
        default: ch = 8'h00;
      endcase
      3'd4: case (c)
        5'd0:  ch = "H";
        5'd1:  ch = "B";
        5'd2:  ch = "L";
        5'd3:  ch = "Z";
        5'd4:  ch = "F";
        5'd5:  ch = "C";
        5'd6:  ch = "P";
        5'd8:  ch = "V";
        5'd9:  ch = "X";
        5'd11: ch = "Q";
        5'd13: ch = "Y";
        5'd14: ch = "J";
        default: ch = 8'h00;
      endcase
      3'd5: case (c)
        5'd0:  ch = "5";
        5'd1:  ch = "6";
        5'd3:  ch = "7";
        5'd7:  ch = "8";
        5'd15: ch = "9";
        5'd16: ch = "4";
        5'd24: ch = "3";
        5'd28: ch = "2";
        5'd30: ch = "1";
        5'd31: ch = "0";
        default: ch = 8'h00;
      endcase
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && (!m_tvalid_o || m_tready_i);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok    = s_tvalid_i && (!fifo_full || pop);
  assign push_drop  = s_tvalid_i && fifo_full && !pop;

  assign head      = mem[rd_ptr];
  assign head_data = head[TOK_W-1:MORSE_SIZE_WIDTH_MAX_C];
  assign head_size = head[MORSE_SIZE_WIDTH_MAX_C-1:0];

  assign head_is_char = (int'(head_size) >= 1) && (int'(head_size) <= 5);
  assign sz3          = 3'(head_size);
  assign code_raw     = 5'(head_data);
  assign code_mask    = (5'd1 << sz3) - 5'd1;
  assign code         = code_raw & code_mask;
  assign lookup_ch    = morse_lookup(sz3, code);

  always_comb begin
    emit      = 1'b0;
    emit_ch   = 8'h00;
    unknown   = 1'b0;
    nxt_state = state;
    if (!head_is_char) begin
      if (state == ST_IN_WORD) begin
        emit      = 1'b1;
        emit_ch   = 8'h20;
        nxt_state = ST_AFTER_GAP;
      end
    end else if (lookup_ch != 8'h00) begin
      emit      = 1'b1;
      emit_ch   = lookup_ch;
      nxt_state = ST_IN_WORD;
    end else begin
      unknown = 1'b1;
      if (UNKNOWN_DROP == 0) begin
        emit      = 1'b1;
        emit_ch   = 8'h3F;
        nxt_state = ST_IN_WORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {s_tdata_i, s_tsize_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= 8'h00;
      overflow_o <= 1'b0;
      err_cnt_o  <= '0;
      state      <= ST_START;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (pop && emit) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= emit_ch;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end

      // clear_i takes priority over any same-cycle FSM, overflow or error event.
      if (clear_i) begin
        state      <= ST_START;
        overflow_o <= 1'b0;
        err_cnt_o  <= '0;
      end else begin
        if (pop) state <= nxt_state;
        if (push_drop) overflow_o <= 1'b1;
        if (pop && unknown && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_morse_char_decoder.sv
// Scoreboard bench for morse_char_decoder: one instance emits '?' on unknown patterns,
// a second drops them; expected beats are queued at stimulus time and popped by a monitor.
module tb_morse_char_decoder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       a_tvalid, a_mvalid, a_ready, a_ovf, a_clear;
  logic [4:0] a_tdata;
  logic [2:0] a_tsize;
  logic [7:0] a_mdata, a_err;

  logic       b_tvalid, b_mvalid, b_ready, b_ovf, b_clear;
  logic [4:0] b_tdata;
  logic [2:0] b_tsize;
  logic [7:0] b_mdata, b_err;

  morse_char_decoder #(.FIFO_DEPTH(8), .UNKNOWN_DROP(0), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .resetn(resetn),
    .s_tvalid_i(a_tvalid), .s_tdata_i(a_tdata), .s_tsize_i(a_tsize),
    .m_tvalid_o(a_mvalid), .m_tdata_o(a_mdata), .m_tready_i(a_ready),
    .overflow_o(a_ovf), .err_cnt_o(a_err), .clear_i(a_clear)
  );

  morse_char_decoder #(.FIFO_DEPTH(8), .UNKNOWN_DROP(1), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .resetn(resetn),
    .s_tvalid_i(b_tvalid), .s_tdata_i(b_tdata), .s_tsize_i(b_tsize),
    .m_tvalid_o(b_mvalid), .m_tdata_o(b_mdata), .m_tready_i(b_ready),
    .overflow_o(b_ovf), .err_cnt_o(b_err), .clear_i(b_clear)
  );

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat is transferred on the next rising edge when valid and ready are high.
  always @(negedge clk) begin
    if (resetn) begin
      if (a_mvalid && a_ready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL beat_a_unexpected: got 0x%0h expected no beat at %0t", a_mdata, $time);
        end else begin
          check("beat_a", a_mdata, qa.pop_front());
        end
      end
      if (b_mvalid && b_ready) begin
        if (qb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL beat_b_unexpected: got 0x%0h expected no beat at %0t", b_mdata, $time);
        end else begin
          check("beat_b", b_mdata, qb.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic tok_a(input logic [4:0] d, input logic [2:0] s);
    a_tvalid = 1'b1; a_tdata = d; a_tsize = s;
    @(posedge clk); #1;
    a_tvalid = 1'b0;
  endtask

  task automatic tok_b(input logic [4:0] d, input logic [2:0] s);
    b_tvalid = 1'b1; b_tdata = d; b_tsize = s;
    @(posedge clk); #1;
    b_tvalid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d/%0d beats pending expected 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
    idle(3);
  endtask

  task automatic pulse_clear(input logic ca, input logic cb);
    a_clear = ca; b_clear = cb;
    @(posedge clk); #1;
    a_clear = 1'b0; b_clear = 1'b0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [4:0] t2_d [5] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0};
  logic [2:0] t2_s [5] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd1};
  logic [7:0] t2_e [5] = '{8'h53, 8'h4F, 8'h53, 8'h20, 8'h45};
  logic [4:0] t4_d [10] = '{5'd2, 5'd1, 5'd5, 5'd1, 5'd0, 5'd4, 5'd3, 5'd0, 5'd0, 5'd14};
  logic [2:0] t4_s [10] = '{3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4, 3'd2, 3'd4};

  initial begin
    a_tvalid = 0; a_tdata = 0; a_tsize = 0; a_ready = 1; a_clear = 0;
    b_tvalid = 0; b_tdata = 0; b_tsize = 0; b_ready = 1; b_clear = 0;
    resetn = 1'b0;
    idle(3);
    check("rst_valid", a_mvalid, 0);
    check("rst_data", a_mdata, 8'h00);
    check("rst_ovf", a_ovf, 0);
    check("rst_err", a_err, 0);
    resetn = 1'b1;
    idle(2);

    // T1: single 'A', latency one edge after sampling.
    qa.push_back(8'h41);
    tok_a(5'b00010, 3'd2);
    check("t1_valid_at_e0", a_mvalid, 0);
    idle(1);
    check("t1_valid_at_e1", a_mvalid, 1);
    check("t1_data_at_e1", a_mdata, 8'h41);
    drain();
    check("t1_err", a_err, 0);

    // T2: S O S <gap> E
    for (int i = 0; i < 5; i++) qa.push_back(t2_e[i]);
    for (int i = 0; i < 5; i++) begin
      tok_a(t2_d[i], t2_s[i]);
      idle(3);
    end
    drain();

    // T3: leading gap dropped, repeated gaps collapsed; T has junk upper bits.
    pulse_clear(1'b1, 1'b0);
    qa.push_back(8'h54); qa.push_back(8'h20); qa.push_back(8'h45);
    tok_a(5'b10101, 3'd0);
    tok_a(5'b11101, 3'd1);
    tok_a(5'b00000, 3'd7);
    tok_a(5'b00000, 3'd6);
    tok_a(5'b00000, 3'd1);
    drain();

    // T4: stalled output, 10 tokens into FIFO_DEPTH=8; 10th dropped.
    a_ready = 1'b0;
    for (int i = 0; i < 9; i++) qa.push_back(8'h41 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      tok_a(t4_d[i], t4_s[i]);
      check("t4_ovf", a_ovf, (i == 9));
    end
    check("t4_stall_valid", a_mvalid, 1);
    check("t4_stall_data", a_mdata, 8'h41);
    idle(3);
    check("t4_stall_data_held", a_mdata, 8'h41);
    a_ready = 1'b1;
    drain();
    check("t4_ovf_sticky", a_ovf, 1);
    pulse_clear(1'b1, 1'b0);
    check("t4_ovf_cleared", a_ovf, 0);

    // T5: unknown pattern; '?' counts as a char so a following gap emits a space.
    qa.push_back(8'h3F); qa.push_back(8'h20);
    tok_a(5'b01100, 3'd4);
    tok_a(5'b00000, 3'd7);
    drain();
    check("t5_err_a", a_err, 1);
    tok_b(5'b01100, 3'd4);
    idle(4);
    check("t5_err_b", b_err, 1);
    qb.push_back(8'h45);
    tok_b(5'b00000, 3'd1);
    drain();
    pulse_clear(1'b1, 1'b1);
    check("t5_clear_a", a_err, 0);
    check("t5_clear_b", b_err, 0);
    tok_b(5'b01100, 3'd4);
    b_clear = 1'b1;
    idle(1);
    b_clear = 1'b0;
    idle(2);
    check("t5_clear_wins", b_err, 0);
    repeat (300) tok_b(5'b01100, 3'd4);
    idle(4);
    check("t5_err_saturate", b_err, 8'hFF);
    pulse_clear(1'b0, 1'b1);
    check("t5_err_sat_clear", b_err, 0);

    // T6: reset with tokens queued and a beat pending.
    a_ready = 1'b0;
    tok_a(5'd0, 3'd1);
    tok_a(5'd1, 3'd1);
    tok_a(5'd0, 3'd2);
    tok_a(5'd3, 3'd2);
    check("t6_pending", a_mvalid, 1);
    resetn = 1'b0;
    a_ready = 1'b1;
    idle(1);
    resetn = 1'b1;
    check("t6_valid_after_rst", a_mvalid, 0);
    idle(10);
    check("t6_no_beats", a_mvalid, 0);
    qa.push_back(8'h4E);
    tok_a(5'b00001, 3'd2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
